// File: rtl/wb_arb.sv
// Write-back arbiter: pipe writes win the register-file port, MDU results
// queue in a small FIFO and drain on idle W-stage cycles.
module wb_arb #(
  parameter int FIFO_DEPTH   = 2,
  parameter int STARVE_LIMIT = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pipe_wen,
  input  logic [4:0]  pipe_wadd,
  input  logic [31:0] pipe_wdat,
  input  logic [31:0] pipe_pc,
  input  logic        mdu_valid,
  output logic        mdu_ready,
  input  logic [4:0]  mdu_wadd,
  input  logic [31:0] mdu_wdat,
  input  logic [31:0] mdu_pc,
  output logic [4:0]  wadd,
  output logic        GRFwen,
  output logic [31:0] wdat,
  output logic [31:0] wpc,
  output logic [31:0] busy_mask,
  output logic        stall_req
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef struct packed {
    logic [4:0]  wadd;
    logic [31:0] wdat;
    logic [31:0] pc;
  } ent_t;

  ent_t                  ent_q [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] vld_q, vld_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [2:0]            age_q, age_d;

  logic        grfwen_q, grfwen_d;
  logic [4:0]  wadd_q, wadd_d;
  logic [31:0] wdat_q, wdat_d;
  logic [31:0] wpc_q, wpc_d;

  logic live, push, pop;
  ent_t head;

  function automatic logic [PW-1:0] inc(
    input logic [PW-1:0] p
  );
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign live      = pipe_wen && (pipe_wadd != 5'd0);
  assign mdu_ready = (count_q < CW'(FIFO_DEPTH));
  assign push      = mdu_valid && mdu_ready
                     && (mdu_wadd != 5'd0);
  assign pop       = !live && (count_q != '0);
  assign head      = ent_q[rd_ptr_q];

  assign stall_req = (count_q == CW'(FIFO_DEPTH))
                     || (age_q == 3'(STARVE_LIMIT));

  always_comb begin
    busy_mask = '0;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (vld_q[i]) begin
        busy_mask = busy_mask
                    | (32'd1 << ent_q[i].wadd);
      end
    end
    busy_mask[0] = 1'b0;
  end

  always_comb begin
    vld_d    = vld_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    age_d    = age_q;
    grfwen_d = 1'b0;
    wadd_d   = wadd_q;
    wdat_d   = wdat_q;
    wpc_d    = wpc_q;

    unique case (1'b1)
      live: begin
        grfwen_d = 1'b1;
        wadd_d   = pipe_wadd;
        wdat_d   = pipe_wdat;
        wpc_d    = pipe_pc;
      end
      pop: begin
        grfwen_d = 1'b1;
        wadd_d   = head.wadd;
        wdat_d   = head.wdat;
        wpc_d    = head.pc;
      end
      default: ;
    endcase

    if (pop) begin
      vld_d[rd_ptr_q] = 1'b0;
      rd_ptr_d        = inc(rd_ptr_q);
    end
    if (push) begin
      vld_d[wr_ptr_q] = 1'b1;
      wr_ptr_d        = inc(wr_ptr_q);
    end

    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    // Age tracks how long the current head has waited.
    if (count_q == '0 || pop) begin
      age_d = '0;
    end else if (age_q != 3'(STARVE_LIMIT)) begin
      age_d = age_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        ent_q[i] <= '0;
      end
      vld_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      age_q    <= '0;
      grfwen_q <= 1'b0;
      wadd_q   <= '0;
      wdat_q   <= '0;
      wpc_q    <= '0;
    end else begin
      if (push) begin
        ent_q[wr_ptr_q] <= '{
          wadd: mdu_wadd,
          wdat: mdu_wdat,
          pc:   mdu_pc
        };
      end
      vld_q    <= vld_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      age_q    <= age_d;
      grfwen_q <= grfwen_d;
      wadd_q   <= wadd_d;
      wdat_q   <= wdat_d;
      wpc_q    <= wpc_d;
    end
  end

  assign GRFwen = grfwen_q;
  assign wadd   = wadd_q;
  assign wdat   = wdat_q;
  assign wpc    = wpc_q;

endmodule

// File: doc/wb_arb.md
WB_ARB -- requirements
Module: wb_arb

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 2, the number of MDU result entries buffered (fixed at 2 for this revision).
REQ-002 SHALL have parameter STARVE_LIMIT, default 7, the head-entry wait in cycles that forces a stall request.
REQ-003 SHALL have port clk  input  1  clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port pipe_wen  input  1  W-stage register write request.
REQ-006 SHALL have port pipe_wadd  input  5  W-stage destination register.
REQ-007 SHALL have port pipe_wdat  input  32  W-stage write data.
REQ-008 SHALL have port pipe_pc  input  32  W-stage instruction PC.
REQ-009 SHALL have port mdu_valid  input  1  MDU result offered.
REQ-010 SHALL have port mdu_ready  output  1  result buffer can accept.
REQ-011 SHALL have ports mdu_wadd, mdu_wdat, mdu_pc  input  5/32/32  MDU result destination, data and PC.
REQ-012 SHALL have ports wadd, GRFwen, wdat, wpc  output  5/1/32/32  register-file write port, all registered.
REQ-013 SHALL have port busy_mask  output  32  bit i = register i has a buffered, unwritten MDU result.
REQ-014 SHALL have port stall_req  output  1  request to hold pipe_wen low next cycle.

Function
REQ-015 SHALL define a pipe write as live when pipe_wen=1 and pipe_wadd!=0.
REQ-016 SHALL accept an MDU result on an edge where mdu_valid=1 and mdu_ready=1 (handshake).
REQ-017 SHALL discard an accepted MDU result with mdu_wadd=0 without enqueueing it.
REQ-018 SHALL drive mdu_ready = (count < FIFO_DEPTH), combinational from the registered count.
REQ-019 SHALL, on each edge, load the output registers with the live pipe write, latency 1, with GRFwen=1.
REQ-020 SHALL, when no pipe write is live and the FIFO is non-empty, pop the head into the output registers with GRFwen=1.
REQ-021 SHALL, when neither source applies, load GRFwen=0 and hold wadd/wdat/wpc at their previous values.
REQ-022 SHALL give the pipe write strict priority; the MDU path never overrides a live pipe write.
REQ-023 SHALL NOT bypass the FIFO; an MDU result accepted into an empty FIFO reaches the outputs no earlier than 2 edges after acceptance.
REQ-024 SHALL, on a simultaneous push and pop, write the new entry behind the remaining entries; count is unchanged.
REQ-025 SHALL keep FIFO order; results are written in acceptance order.
REQ-026 SHALL compute busy_mask combinationally as the OR of the one-hot decodes of all valid FIFO entries' wadd; bit 0 is always 0.
REQ-027 SHALL keep a 3-bit age counter: cleared on pop or when the FIFO is empty, otherwise incremented while the FIFO is non-empty, saturating at STARVE_LIMIT.
REQ-028 SHALL assert stall_req = (count==FIFO_DEPTH) OR (age==STARVE_LIMIT), combinationally.
REQ-029 SHALL treat a live pipe write arriving while stall_req=1 normally; stall_req is advisory and no data is lost.

Reset
REQ-030 SHALL, on an edge with rst=1, clear count, age, all FIFO entries, GRFwen, wadd, wdat and wpc to 0.
REQ-031 SHALL drop any in-flight MDU handshake on a reset edge; mdu_ready=1 from the first cycle after reset.
REQ-032 SHALL ignore pipe and MDU inputs on reset edges.

Verification
REQ-033 SHALL verify: pipe_wen=1, wadd=5, wdat=0xDEADBEEF, pc=0x3000 -> next cycle GRFwen=1, wadd=5, wdat=0xDEADBEEF, wpc=0x3000.
REQ-034 SHALL verify: MDU push wadd=8, wdat=0x11 with pipe idle -> busy_mask=0x100 for one cycle, then GRFwen=1, wadd=8, wdat=0x11, busy_mask=0.
REQ-035 SHALL verify: two MDU pushes (regs 8, 9) while pipe_wen=1 to reg 3 every cycle -> mdu_ready=0, stall_req=1; after pipe goes idle, reg 8 then reg 9 written on consecutive edges.
REQ-036 SHALL verify: one entry buffered, pipe live for 7 cycles -> stall_req=1 at age 7; first idle cycle pops it and age returns to 0.
REQ-037 SHALL verify: MDU push with wadd=0 -> accepted, count stays 0, GRFwen stays 0.
REQ-038 SHALL verify: rst asserted with 2 entries buffered -> next cycle count=0, busy_mask=0, GRFwen=0, mdu_ready=1.
